// File: rtl/synth_cmd_pkg.sv
// Shared constants, state encoding and opcode helpers for the FM synth command parser.
package synth_cmd_pkg;

    localparam int unsigned FCW_W   = 24;
    localparam int unsigned SHIFT_W = 5;

    localparam logic [7:0] OP_MOD_FCW     = 8'h01;
    localparam logic [7:0] OP_MOD_SHIFT   = 8'h02;
    localparam logic [7:0] OP_NOTE_START  = 8'h03;
    localparam logic [7:0] OP_NOTE_STOP   = 8'h04;
    localparam logic [7:0] OP_SYNTH_SHIFT = 8'h05;
    localparam logic [7:0] OP_ALL_OFF     = 8'h06;

    typedef enum logic [1:0] {StIdle, StPayload, StScan, StApply} state_e;

    // Number of payload bytes that follow an opcode; 0 for no-payload or unknown opcodes.
    function automatic logic [1:0] payload_len(input logic [7:0] op);
        case (op)
            OP_MOD_FCW, OP_NOTE_START, OP_NOTE_STOP: payload_len = 2'd3;
            OP_MOD_SHIFT, OP_SYNTH_SHIFT:            payload_len = 2'd1;
            default:                                 payload_len = 2'd0;
        endcase
    endfunction

    function automatic logic op_known(input logic [7:0] op);
        op_known = (op >= OP_MOD_FCW) && (op <= OP_ALL_OFF);
    endfunction

endpackage

// File: rtl/synth_voice_scan.sv
// Sequential voice scanner: walks voices 0..N-1, one per cycle, recording the lowest free voice
// and the lowest enabled voice whose FCW equals the requested FCW.
module synth_voice_scan
    import synth_cmd_pkg::*;
#(
    parameter int unsigned N_VOICES = 4,
    localparam int unsigned IDX_W = (N_VOICES > 1) ? $clog2(N_VOICES) : 1
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_start,
    input  logic [FCW_W-1:0]          i_fcw,
    input  logic [N_VOICES-1:0]       i_note_en,
    input  logic [FCW_W*N_VOICES-1:0] i_carrier_fcws,
    output logic                      o_done,
    output logic                      o_free_found,
    output logic [IDX_W-1:0]          o_free_idx,
    output logic                      o_match_found,
    output logic [IDX_W-1:0]          o_match_idx
);

    logic             r_active;
    logic [IDX_W-1:0] r_idx;
    logic             r_free_found;
    logic [IDX_W-1:0] r_free_idx;
    logic             r_match_found;
    logic [IDX_W-1:0] r_match_idx;

    logic [FCW_W-1:0] w_voice_fcw;
    logic             w_voice_en;
    logic             w_last;

    // Select the voice under examination this cycle.
    always_comb begin
        w_voice_fcw = '0;
        w_voice_en  = 1'b0;
        for (int v = 0; v < N_VOICES; v++) begin
            if (r_idx == IDX_W'(v)) begin
                w_voice_fcw = i_carrier_fcws[v*FCW_W +: FCW_W];
                w_voice_en  = i_note_en[v];
            end
        end
        w_last = r_active && (r_idx == IDX_W'(N_VOICES - 1));
    end

    // Walk the voices and keep only the first hit of each kind.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_active      <= 1'b0;
            r_idx         <= '0;
            r_free_found  <= 1'b0;
            r_free_idx    <= '0;
            r_match_found <= 1'b0;
            r_match_idx   <= '0;
        end else if (i_start) begin
            r_active      <= 1'b1;
            r_idx         <= '0;
            r_free_found  <= 1'b0;
            r_free_idx    <= '0;
            r_match_found <= 1'b0;
            r_match_idx   <= '0;
        end else if (r_active) begin
            if (!w_voice_en && !r_free_found) begin
                r_free_found <= 1'b1;
                r_free_idx   <= r_idx;
            end
            if (w_voice_en && (w_voice_fcw == i_fcw) && !r_match_found) begin
                r_match_found <= 1'b1;
                r_match_idx   <= r_idx;
            end
            if (w_last) begin
                r_active <= 1'b0;
            end else begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

    // Done is raised while the last voice is examined so the owner can step on that same edge.
    always_comb begin
        o_done        = w_last;
        o_free_found  = r_free_found;
        o_free_idx    = r_free_idx;
        o_match_found = r_match_found;
        o_match_idx   = r_match_idx;
    end

endmodule

// File: rtl/synth_cmd_parser.sv
// UART byte-stream command front end for the FM synth: decodes opcodes, assembles payloads,
// allocates/frees carrier voices and drives the synth control registers.
module synth_cmd_parser
    import synth_cmd_pkg::*;
#(
    parameter int unsigned N_VOICES       = 4,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic [7:0]                i_rx_data,
    input  logic                      i_rx_valid,
    output logic                      o_rx_ready,
    output logic [FCW_W-1:0]          o_mod_fcw,
    output logic [SHIFT_W-1:0]        o_mod_shift,
    output logic [SHIFT_W-1:0]        o_synth_shift,
    output logic [FCW_W*N_VOICES-1:0] o_carrier_fcws,
    output logic [N_VOICES-1:0]       o_note_en,
    output logic                      o_busy,
    output logic                      o_cmd_err
);

    localparam int unsigned IDX_W = (N_VOICES > 1) ? $clog2(N_VOICES) : 1;
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    state_e                    r_state;
    state_e                    w_state_d;
    logic [7:0]                r_op;
    logic [1:0]                r_cnt;
    logic [FCW_W-1:0]          r_asm;
    logic [TMO_W-1:0]          r_tmo;
    logic                      r_commit;
    logic [FCW_W-1:0]          r_mod_fcw;
    logic [SHIFT_W-1:0]        r_mod_shift;
    logic [SHIFT_W-1:0]        r_synth_shift;
    logic [FCW_W*N_VOICES-1:0] r_fcws;
    logic [N_VOICES-1:0]       r_note_en;
    logic                      r_cmd_err;

    logic                      w_accept;
    logic                      w_is_note_op;
    logic                      w_last_byte;
    logic                      w_scan_start;
    logic                      w_timeout;
    logic                      w_scan_done;
    logic                      w_free_found;
    logic [IDX_W-1:0]          w_free_idx;
    logic                      w_match_found;
    logic [IDX_W-1:0]          w_match_idx;

    // Handshake and command-progress decode.
    always_comb begin
        w_accept     = i_rx_valid && o_rx_ready;
        w_is_note_op = (r_op == OP_NOTE_START) || (r_op == OP_NOTE_STOP);
        w_last_byte  = w_accept && (r_state == StPayload) && (r_cnt == 2'd1);
        w_scan_start = w_last_byte && w_is_note_op;
        w_timeout    = (r_state == StPayload) && !w_accept
                       && (r_tmo == TMO_W'(TIMEOUT_CYCLES - 1));
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_d = r_state;
        case (r_state)
            StIdle: begin
                if (w_accept && (payload_len(i_rx_data) != 2'd0)) w_state_d = StPayload;
            end
            StPayload: begin
                if (w_last_byte)    w_state_d = w_is_note_op ? StScan : StIdle;
                else if (w_timeout) w_state_d = StIdle;
            end
            StScan: begin
                if (w_scan_done) w_state_d = StApply;
            end
            default: w_state_d = StIdle;
        endcase
    end

    // FSM outputs.
    always_comb begin
        o_rx_ready = (r_state == StIdle) || (r_state == StPayload);
        o_busy     = (r_state != StIdle);
    end

    // Opcode/payload capture, timeout counter and deferred-commit flag.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_op     <= '0;
            r_cnt    <= '0;
            r_asm    <= '0;
            r_tmo    <= '0;
            r_commit <= 1'b0;
        end else begin
            r_commit <= 1'b0;
            if ((r_state == StPayload) && !w_accept && !w_timeout) r_tmo <= r_tmo + 1'b1;
            else                                                  r_tmo <= '0;
            if (w_accept) begin
                if (r_state == StIdle) begin
                    r_op     <= i_rx_data;
                    r_cnt    <= payload_len(i_rx_data);
                    r_commit <= (i_rx_data == OP_ALL_OFF);
                end else begin
                    // LSB first: each byte enters at the top and slides down.
                    r_asm    <= {i_rx_data, r_asm[FCW_W-1:8]};
                    r_cnt    <= r_cnt - 2'd1;
                    r_commit <= (r_cnt == 2'd1) && !w_is_note_op;
                end
            end
        end
    end

    // Control registers change only when a command completes.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_mod_fcw     <= '0;
            r_mod_shift   <= '0;
            r_synth_shift <= '0;
            r_fcws        <= '0;
            r_note_en     <= '0;
            r_cmd_err     <= 1'b0;
        end else begin
            r_cmd_err <= 1'b0;
            if (r_commit) begin
                // Single-byte payloads sit in the top byte of the assembly register.
                case (r_op)
                    OP_MOD_FCW:     r_mod_fcw     <= r_asm;
                    OP_MOD_SHIFT:   r_mod_shift   <= r_asm[FCW_W-8 +: SHIFT_W];
                    OP_SYNTH_SHIFT: r_synth_shift <= r_asm[FCW_W-8 +: SHIFT_W];
                    OP_ALL_OFF:     r_note_en     <= '0;
                    default:        ;
                endcase
            end
            if (w_accept && (r_state == StIdle) && !op_known(i_rx_data)) r_cmd_err <= 1'b1;
            if (w_timeout) r_cmd_err <= 1'b1;
            if (r_state == StApply) begin
                if (r_op == OP_NOTE_START) begin
                    if (!w_match_found) begin
                        if (w_free_found) begin
                            for (int v = 0; v < N_VOICES; v++) begin
                                if (w_free_idx == IDX_W'(v)) begin
                                    r_fcws[v*FCW_W +: FCW_W] <= r_asm;
                                    r_note_en[v]             <= 1'b1;
                                end
                            end
                        end else begin
                            r_cmd_err <= 1'b1;
                        end
                    end
                end else if (w_match_found) begin
                    for (int v = 0; v < N_VOICES; v++) begin
                        if (w_match_idx == IDX_W'(v)) r_note_en[v] <= 1'b0;
                    end
                end
            end
        end
    end

    synth_voice_scan #(
        .N_VOICES (N_VOICES)
    ) u_scan (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_start        (w_scan_start),
        .i_fcw          (r_asm),
        .i_note_en      (r_note_en),
        .i_carrier_fcws (r_fcws),
        .o_done         (w_scan_done),
        .o_free_found   (w_free_found),
        .o_free_idx     (w_free_idx),
        .o_match_found  (w_match_found),
        .o_match_idx    (w_match_idx)
    );

    always_comb begin
        o_mod_fcw      = r_mod_fcw;
        o_mod_shift    = r_mod_shift;
        o_synth_shift  = r_synth_shift;
        o_carrier_fcws = r_fcws;
        o_note_en      = r_note_en;
        o_cmd_err      = r_cmd_err;
    end

endmodule
